// File: rtl/dota_sd_reader.sv
// First-order sigma-delta readout for the digital OTA/comparator cell: synchronizes the
// comparator, drives the 1-bit feedback level and counts ones over 2^N-1 cycle windows.
module dota_sd_reader #(
  parameter int OSR_LOG2      = 8,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                cmp_in,
  output logic                fb_out,
  output logic [OSR_LOG2-1:0] data_out,
  output logic                data_valid,
  input  logic                data_ready,
  output logic                overrun,
  output logic                busy
);

  localparam int N  = OSR_LOG2;
  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = (N > SW) ? N : SW;

  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [CW-1:0] WIN_LAST    = CW'((1 << N) - 2);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETTLE = 2'd1;
  localparam logic [1:0] INTEG  = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cyc;
  logic [N-1:0]  ones;
  logic          sync1, cmp_s;
  logic          win_done, hs;
  logic [N-1:0]  win_sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= 1'b0;
      cmp_s <= 1'b0;
    end else begin
      sync1 <= cmp_in;
      cmp_s <= sync1;
    end
  end

  // Final count includes the sample taken on the completing edge; it never exceeds 2^N-1.
  assign win_sum  = ones + {{(N-1){1'b0}}, cmp_s};
  assign win_done = en && (state == INTEG) && (cyc == WIN_LAST);
  assign hs       = data_valid && data_ready;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cyc   <= '0;
      ones  <= '0;
    end else if (!en) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          state <= SETTLE;
          cyc   <= '0;
        end
        SETTLE: begin
          if (cyc == SETTLE_LAST) begin
            state <= INTEG;
            cyc   <= '0;
            ones  <= '0;
          end else begin
            cyc <= cyc + CW'(1);
          end
        end
        INTEG: begin
          if (cyc == WIN_LAST) begin
            cyc  <= '0;
            ones <= '0;
          end else begin
            cyc  <= cyc + CW'(1);
            ones <= win_sum;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Feedback is gated by en as well so it drops on the same edge the loop goes idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fb_out     <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      fb_out <= (en && state != IDLE) ? cmp_s : 1'b0;
      if (win_done && data_valid && !data_ready)
        overrun <= 1'b1;
      else if (hs)
        overrun <= 1'b0;
      if (win_done && (!data_valid || data_ready)) begin
        data_out   <= win_sum;
        data_valid <= 1'b1;
      end else if (hs) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
